// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared types and constants for the matmul scheduler slice
package matmul_pkg;

    localparam int DEF_NUM_CLIENTS    = 2;
    localparam int DEF_DATA1_LEN_BITS = 2;
    localparam int DEF_DATA2_ROW_BITS = 2;
    localparam int DEF_DATA2_COL_BITS = 4;

    localparam logic [15:0] Q_ONE       = 16'h0100;
    localparam int          Q_FRAC_BITS = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_COMPUTE,
        S_DRAIN,
        S_DONE
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter, client after i_ptr has top priority
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt
);

    logic [PW-1:0] w_idx;
    logic          w_found;

    always_comb begin
        o_gnt   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int i = 1; i <= N; i++) begin
            w_idx = PW'((int'(i_ptr) + i) % N);
            if (!w_found && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/matmul_sched.sv
// rtl/matmul_sched.sv - shares one matmul engine among several clients,
// launching a job per grant and streaming the result vector back
module matmul_sched
    import matmul_pkg::*;
#(
    parameter int NUM_CLIENTS    = DEF_NUM_CLIENTS,
    parameter int DATA1_LEN_BITS = DEF_DATA1_LEN_BITS,
    parameter int DATA2_ROW_BITS = DEF_DATA2_ROW_BITS,
    parameter int DATA2_COL_BITS = DEF_DATA2_COL_BITS
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CLIENTS-1:0]    i_req,
    output logic [NUM_CLIENTS-1:0]    o_gnt,
    output logic [NUM_CLIENTS-1:0]    o_done,
    input  logic [NUM_CLIENTS*16-1:0] i_cl_data1,
    input  logic [NUM_CLIENTS*16-1:0] i_cl_data2,
    output logic [DATA1_LEN_BITS-1:0] o_addr_vec,
    output logic [DATA2_ROW_BITS-1:0] o_addr_row,
    output logic [DATA2_COL_BITS-1:0] o_addr_col,
    output logic                      o_res_valid,
    output logic [DATA2_COL_BITS-1:0] o_res_idx,
    output logic [15:0]               o_res_data,
    output logic                      o_mm_start,
    input  logic                      i_mm_ready,
    output logic [15:0]               o_mm_data1,
    output logic [15:0]               o_mm_data2,
    output logic [DATA2_COL_BITS-1:0] o_mm_sel,
    input  logic [DATA1_LEN_BITS-1:0] i_mm_sel_vec,
    input  logic [DATA2_ROW_BITS-1:0] i_mm_sel_row,
    input  logic [DATA2_COL_BITS-1:0] i_mm_sel_col,
    input  logic [15:0]               i_mm_data_out
);

    localparam int PW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    sched_state_t              r_state;
    sched_state_t              w_next;
    logic [NUM_CLIENTS-1:0]    r_gnt;
    logic [PW-1:0]             r_ptr;
    logic [DATA2_COL_BITS-1:0] r_sel;
    logic [NUM_CLIENTS-1:0]    w_win;
    logic [PW-1:0]             w_gnt_idx;

    rr_arbiter #(
        .N  (NUM_CLIENTS),
        .PW (PW)
    ) u_arb (
        .i_req (i_req),
        .i_ptr (r_ptr),
        .o_gnt (w_win)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if ((|i_req) && i_mm_ready) w_next = S_LAUNCH;
            S_LAUNCH:  w_next = S_COMPUTE;
            S_COMPUTE: if (i_mm_ready) w_next = S_DRAIN;
            S_DRAIN:   if (&r_sel) w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_gnt_idx = '0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            if (r_gnt[k]) w_gnt_idx = PW'(k);
        end
    end

    // r_sel wraps back to 0 on the last drain beat, so it is already 0 in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_ptr   <= PW'(NUM_CLIENTS - 1);
            r_sel   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_next == S_LAUNCH) begin
                r_gnt <= w_win;
            end else if (r_state == S_DONE) begin
                r_gnt <= '0;
                r_ptr <= w_gnt_idx;
            end
            if (r_state == S_DRAIN) r_sel <= r_sel + 1'b1;
            else                    r_sel <= '0;
        end
    end

    always_comb begin
        o_mm_data1 = '0;
        o_mm_data2 = '0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            if (r_gnt[k]) begin
                o_mm_data1 = i_cl_data1[k*16 +: 16];
                o_mm_data2 = i_cl_data2[k*16 +: 16];
            end
        end
    end

    assign o_gnt       = r_gnt;
    assign o_done      = (r_state == S_DONE) ? r_gnt : '0;
    assign o_mm_start  = (r_state == S_LAUNCH);
    assign o_mm_sel    = r_sel;
    assign o_res_valid = (r_state == S_DRAIN);
    assign o_res_idx   = r_sel;
    assign o_res_data  = (r_state == S_DRAIN) ? i_mm_data_out : 16'h0000;
    assign o_addr_vec  = i_mm_sel_vec;
    assign o_addr_row  = i_mm_sel_row;
    assign o_addr_col  = i_mm_sel_col;

endmodule

// File: tb/tb_matmul_sched.sv
// tb/tb_matmul_sched.sv - directed bench for matmul_sched with an engine stand-in
module tb_matmul_sched;

    localparam int N  = 2;
    localparam int RB = 2;
    localparam int CB = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [N-1:0]  gnt, done;
    logic [N*16-1:0] cl_d1, cl_d2;
    logic [RB-1:0] addr_vec, addr_row;
    logic [CB-1:0] addr_col;
    logic          res_valid;
    logic [CB-1:0] res_idx;
    logic [15:0]   res_data;
    logic          mm_start, mm_ready;
    logic [15:0]   mm_d1, mm_d2, mm_out;
    logic [CB-1:0] mm_sel;
    logic [RB-1:0] e_vec, e_row;
    logic [CB-1:0] e_col;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [CB-1:0] idx;
        logic [15:0]   data;
    } beat_t;
    beat_t exp_q[$];

    logic signed [15:0] v_op [N][4];
    logic signed [15:0] m_op [N][4][16];

    always #5 clk = ~clk;

    matmul_sched u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_req         (req),
        .o_gnt         (gnt),
        .o_done        (done),
        .i_cl_data1    (cl_d1),
        .i_cl_data2    (cl_d2),
        .o_addr_vec    (addr_vec),
        .o_addr_row    (addr_row),
        .o_addr_col    (addr_col),
        .o_res_valid   (res_valid),
        .o_res_idx     (res_idx),
        .o_res_data    (res_data),
        .o_mm_start    (mm_start),
        .i_mm_ready    (mm_ready),
        .o_mm_data1    (mm_d1),
        .o_mm_data2    (mm_d2),
        .o_mm_sel      (mm_sel),
        .i_mm_sel_vec  (e_vec),
        .i_mm_sel_row  (e_row),
        .i_mm_sel_col  (e_col),
        .i_mm_data_out (mm_out)
    );

    // Clients answer operand reads from their own arrays via the broadcast addresses
    always_comb begin
        cl_d1 = '0;
        cl_d2 = '0;
        for (int k = 0; k < N; k++) begin
            cl_d1[k*16 +: 16] = v_op[k][addr_vec];
            cl_d2[k*16 +: 16] = m_op[k][addr_row][addr_col];
        end
    end

    // Engine stand-in: one clear cycle, then R*C multiply-accumulate steps
    int                 e_cnt;
    logic               e_hold;
    logic [5:0]         e_j;
    logic signed [31:0] e_acc [16];
    logic signed [31:0] e_prod;

    assign e_j      = (e_cnt >= 1 && e_cnt <= 64) ? 6'(64 - e_cnt) : 6'd0;
    assign e_vec    = e_j[1:0];
    assign e_row    = e_j[1:0];
    assign e_col    = e_j[5:2];
    assign e_prod   = ($signed(mm_d1) * $signed(mm_d2)) >>> 8;
    assign mm_ready = (e_cnt == 0) && !e_hold;
    assign mm_out   = e_acc[mm_sel][15:0];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_cnt <= 0;
        end else if (mm_start) begin
            e_cnt <= 65;
        end else if (e_cnt > 0) begin
            if (e_cnt == 65) begin
                for (int i = 0; i < 16; i++) e_acc[i] <= 32'sd0;
            end else begin
                e_acc[e_col] <= e_acc[e_col] + e_prod;
            end
            e_cnt <= e_cnt - 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic set_ops(input int cl, input int kind);
        for (int r = 0; r < 4; r++) begin
            case (kind)
                0:       v_op[cl][r] = 16'h0100;
                1:       v_op[cl][r] = 16'h0200;
                default: v_op[cl][r] = 16'((r + 1) * 256);
            endcase
            for (int c = 0; c < 16; c++) begin
                case (kind)
                    0:       m_op[cl][r][c] = 16'h0100;
                    1:       m_op[cl][r][c] = 16'h0080;
                    default: m_op[cl][r][c] = 16'(c * 16 + r * 32 + 16);
                endcase
            end
        end
    endtask

    function automatic logic [15:0] exp_res(input int cl, input int col);
        logic signed [31:0] acc;
        logic signed [31:0] p;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            p   = v_op[cl][i] * m_op[cl][i][col];
            acc = acc + (p >>> 8);
        end
        return acc[15:0];
    endfunction

    // Entered at the negedge of cycle 0; returns at the negedge of cycle 85
    // (or right after releasing reset when rst_cyc is hit).
    task automatic run_job(input int cl, input logic [N-1:0] eg,
                           input logic [N-1:0] early_mask, input int early_cyc,
                           input logic [N-1:0] end_mask, input int rst_cyc);
        beat_t b;
        beat_t e;
        for (int i = 0; i < 16; i++) begin
            e.idx  = CB'(i);
            e.data = exp_res(cl, i);
            exp_q.push_back(e);
        end
        for (int c = 1; c <= 85; c++) begin
            @(negedge clk);
            if (c == rst_cyc) begin
                rst_n = 1'b0;
                #1;
                chk("rst_gnt", gnt, 0);
                chk("rst_done", done, 0);
                chk("rst_start", mm_start, 0);
                chk("rst_valid", res_valid, 0);
                chk("rst_idx", res_idx, 0);
                chk("rst_data", res_data, 0);
                chk("rst_sel", mm_sel, 0);
                chk("rst_d1", mm_d1, 0);
                chk("rst_d2", mm_d2, 0);
                req = '0;
                exp_q.delete();
                repeat (3) begin
                    @(negedge clk);
                    chk("rst_hold_done", done, 0);
                    chk("rst_hold_valid", res_valid, 0);
                end
                rst_n = 1'b1;
                return;
            end
            if (c == 1) begin
                chk("launch_gnt", gnt, eg);
                chk("launch_start", mm_start, 1);
            end
            if (c == 2)  chk("start_pulse", mm_start, 0);
            if (c == 40 || c == 83) chk("held_gnt", gnt, eg);
            chk("res_valid", res_valid, (c >= 68 && c <= 83));
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 0, 1);
                end else begin
                    b = exp_q.pop_front();
                    chk("res_idx", res_idx, b.idx);
                    chk("res_data", res_data, b.data);
                end
            end
            chk("done", done, (c == 84) ? eg : '0);
            if (c == 85) begin
                chk("gnt_clear", gnt, 0);
                chk("sb_empty", exp_q.size(), 0);
            end
            if (c == early_cyc) req = req & ~early_mask;
            if (c == 84)        req = req & ~end_mask;
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        req    = '0;
        e_hold = 1'b0;
        set_ops(0, 0);
        set_ops(1, 1);
        repeat (2) @(negedge clk);
        chk("reset_gnt", gnt, 0);
        chk("reset_done", done, 0);
        chk("reset_valid", res_valid, 0);
        chk("reset_idx", res_idx, 0);
        chk("reset_data", res_data, 0);
        chk("reset_start", mm_start, 0);
        chk("reset_d1", mm_d1, 0);
        chk("reset_sel", mm_sel, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single client
        req = 2'b01;
        run_job(0, 2'b01, 2'b00, 0, 2'b01, 0);
        @(negedge clk);
        chk("idle_no_gnt", gnt, 0);

        // both from reset: client 0 then client 1
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        req = 2'b11;
        run_job(0, 2'b01, 2'b00, 0, 2'b01, 0);
        run_job(1, 2'b10, 2'b00, 0, 2'b10, 0);

        // fairness with both held
        req = 2'b11;
        run_job(0, 2'b01, 2'b00, 0, 2'b00, 0);
        run_job(1, 2'b10, 2'b00, 0, 2'b00, 0);
        run_job(0, 2'b01, 2'b00, 0, 2'b00, 0);
        run_job(1, 2'b10, 2'b00, 0, 2'b11, 0);
        @(negedge clk);
        chk("fair_idle", gnt, 0);

        // request dropped mid-job
        req = 2'b01;
        run_job(0, 2'b01, 2'b01, 20, 2'b00, 0);

        // reset mid-job, then a fresh job with varied operands
        req = 2'b01;
        run_job(0, 2'b01, 2'b00, 0, 2'b01, 40);
        set_ops(1, 2);
        @(negedge clk);
        req = 2'b10;
        run_job(1, 2'b10, 2'b00, 0, 2'b10, 0);

        // engine busy externally: request must wait
        e_hold = 1'b1;
        req    = 2'b01;
        repeat (8) begin
            @(negedge clk);
            chk("busy_gnt", gnt, 0);
            chk("busy_start", mm_start, 0);
        end
        e_hold = 1'b0;
        run_job(0, 2'b01, 2'b00, 0, 2'b01, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/matmul_sched.md
# matmul_sched

Round-robin scheduler that shares one `matmul` engine between `NUM_CLIENTS` requesters. It grants one client at a time and routes the engine's operand addresses to that client. It also muxes the client's Q8.8 operands into the engine, launches the job, and waits for completion. Finally it drains the result vector back to the client as a stream. It sits between the engine and the RNN cell controllers: the input-to-hidden and hidden-to-hidden products.

## Interface
- `NUM_CLIENTS`, 2: number of requesters (≥2).
- `DATA1_LEN_BITS`, 2: log2 of vector length; must match engine.
- `DATA2_ROW_BITS`, 2: log2 of matrix rows; must match engine.
- `DATA2_COL_BITS`, 4: log2 of matrix columns / result length; must match engine.

- `clk`  in  1  clock.
- `rst_n`  in  1  reset: asynchronous, active-low; shared with engine.
- `req`  in  NUM_CLIENTS  job request per client; level, held until `done`.
- `gnt`  out  NUM_CLIENTS  one-hot grant, held for whole job.
- `done`  out  NUM_CLIENTS  one-cycle pulse to granted client at job end.
- `cl_data1`  in  NUM_CLIENTS×16  vector operand per client, Q8.8.
- `cl_data2`  in  NUM_CLIENTS×16  matrix operand per client, Q8.8.
- `addr_vec` / `addr_row` / `addr_col`  out  DATA1_LEN_BITS / DATA2_ROW_BITS / DATA2_COL_BITS  operand addresses, broadcast to all clients.
- `res_valid`  out  1  result element valid.
- `res_idx`  out  DATA2_COL_BITS  result element index.
- `res_data`  out  16  result element, Q8.8.
- `mm_start`  out  1  engine start.
- `mm_ready`  in  1  engine idle.
- `mm_data1` / `mm_data2`  out  16  engine operands.
- `mm_sel`  out  DATA2_COL_BITS  engine result read index.
- `mm_sel_vec` / `mm_sel_row` / `mm_sel_col`  in  engine operand addresses.
- `mm_data_out`  in  16  engine result at `mm_sel`; combinational in `mm_sel`.

## Operation
- **States:** IDLE, LAUNCH, COMPUTE, DRAIN, DONE.
- **IDLE:** if any `req` and `mm_ready`, arbitrate, register one-hot `gnt`, and go to LAUNCH.
  - Otherwise stay.
  - `req` while `mm_ready`=0 waits.
- **Arbitration:** round-robin. The client after the last-granted one has highest priority. The pointer resets so that client 0 wins first. The pointer updates in DONE.
- **LAUNCH:** `mm_start`=1 for exactly one cycle, then go to COMPUTE unconditionally.
- **COMPUTE:** wait for `mm_ready`=1, then go to DRAIN with `mm_sel`=0.
  - `mm_ready` is already low in the first COMPUTE cycle.
- **DRAIN:** `mm_sel` increments each cycle from 0 to 2^DATA2_COL_BITS−1.
  - `res_valid`=1, `res_idx`=`mm_sel`, `res_data`=`mm_data_out` in the same cycle.
  - After the last index, go to DONE. There is no backpressure.
- **DONE:** `done[g]`=1 for one cycle, `gnt` cleared, pointer←g, go to IDLE.
- **Operand mux:** `mm_data1`/`mm_data2` = the granted client's `cl_data1`/`cl_data2`; 0 when no grant.
- **Address routing:** `addr_*` = `mm_sel_*` combinationally.
- **`mm_sel`:** 0 outside DRAIN.
- **Request handling:**
  - `req` dropping mid-job is ignored; the job completes and `done` still pulses.
  - `req` changes of other clients during a job affect only the next arbitration.
- **Reset values:** `gnt`=0, `done`=0, `res_valid`=0, `res_idx`=0, `res_data`=0 (`mm_sel`=0), `mm_start`=0, `mm_data1`/`mm_data2`=0, state=IDLE, pointer=NUM_CLIENTS−1.
- **Reset mid-job:** immediate return to IDLE with the reset values; the engine resets on the same `rst_n`. No `done` is issued.

## Timing
- Cycle 0 is the IDLE cycle with `req` and `mm_ready` high.
- Cycle 1: LAUNCH, `gnt` and `mm_start` high.
- Cycle 2: engine clear.
- Cycles 3 to 2+R·C: engine busy, where R=2^DATA1_LEN_BITS and C=2^DATA2_COL_BITS.
- Cycle 3+R·C: `mm_ready` rises.
- DRAIN runs C cycles starting at 4+R·C.
- `done` fires at 4+R·C+C. IDLE follows the next cycle.
- Defaults (R=4, C=16): drain in cycles 68–83, `done` at 84.
- Back-to-back jobs: the next grant is earliest at `done`+2.

## Structure
- `matmul_pkg`: state enum `sched_state_t`, Q8.8 constants (`Q_ONE`=16'h0100, `Q_FRAC_BITS`=8), default width parameters.
- Sub-module `rr_arbiter`: parameterised by N; inputs `req`, pointer; output one-hot winner.
- Operand mux, address fan-out and the FSM live in `matmul_sched`.

## Test plan
- **Single client, defaults:** client 0 drives all `cl_data1`=16'h0100 and all `cl_data2`=16'h0100 → `gnt`=2'b01 at cycle 1; 16 `res_valid` beats in cycles 68–83, each `res_data`=16'h0400, `res_idx` 0..15; `done[0]` at 84.
- **Both `req` high from reset:** client 0 is served first, then client 1. Client 1 operands are 16'h0200 × 16'h0080 → each result 16'h0400. The `gnt` sequence is 01, 00, 10.
- **Fairness:** both requests held continuously for 4 jobs → grants alternate 0, 1, 0, 1; no `gnt` overlap.
- **Request drop:** client 0 drops `req` in cycle 20 → job completes, 16 beats, `done[0]` at 84.
- **Reset mid-job:** `rst_n` asserted low in cycle 40 → all outputs at reset values within the same cycle, no `done`. A new `req` after release restarts from cycle 0 timing.
- **Engine not ready:** `mm_ready` held low externally while `req`=1 → no `gnt` and no `mm_start` until `mm_ready` rises.
